// File: rtl/cae_csr_pkg.sv
// ----------------------------------------------------------------------------
// cae_csr_pkg
// Shared definitions for the CAE CSR function-side arbiter.
//   - CSR address map constants used by the local requesters
//   - Arbiter FSM state type and encodings
//   - Default read-ack timeout in clk_csr cycles
// No ports (package).
// ----------------------------------------------------------------------------
package cae_csr_pkg;

    // CSR address map seen on the bank's function-side port
    localparam logic [15:0] CSR_STATUS   = 16'h0001;
    localparam logic [15:0] CSR_VIS      = 16'h0002;
    localparam logic [15:0] CSR_SCRATCH  = 16'h0003;
    localparam logic [15:0] CSR_SUM      = 16'h0004;
    localparam logic [15:0] CSR_SEL_MASK = 16'h8000;

    // Arbiter sequencer states, kept as plain constants so older tools and
    // waveform scripts that expect a 2-bit code keep working
    typedef logic [1:0] csr_state_t;
    localparam csr_state_t ST_IDLE  = 2'd0;
    localparam csr_state_t ST_ISSUE = 2'd1;
    localparam csr_state_t ST_WAIT  = 2'd2;
    localparam csr_state_t ST_RESP  = 2'd3;

    // Cycles to wait for func_ack on a read before flagging an error
    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/cae_rr_pick.sv
// ----------------------------------------------------------------------------
// cae_rr_pick
// Combinational round-robin priority encoder. Starting at ptr_i and walking
// upward (wrapping modulo N), the first set bit of vec_i wins.
// Ports:
//   vec_i  [N-1:0]   request vector
//   ptr_i  [IW-1:0]  index with highest priority this cycle
//   gnt_o  [N-1:0]   one-hot winner (all zero when nothing requests)
//   idx_o  [IW-1:0]  binary index of the winner
//   any_o            at least one request present
// ----------------------------------------------------------------------------
module cae_rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand;

    // Visit candidates in priority order; once a winner is found the
    // any_o flag masks every later candidate.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int off = 0; off < N; off++) begin
            cand = IW'((int'(ptr_i) + off) % N);
            if (!any_o && vec_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/cae_csr_arb.sv
// ----------------------------------------------------------------------------
// cae_csr_arb
// Round-robin arbiter/sequencer sharing the CSR bank function-side port
// between NREQ local requesters. One access in flight at a time; every
// accepted access ends with a one-cycle rsp_vld pulse, including reads that
// time out waiting for func_ack.
// Ports:
//   clk_csr, i_csr_reset_n           clock, async active-low reset
//   req_vld/req_wr [NREQ]            per-requester request and direction
//   req_addr [NREQ*AW], req_wdata [NREQ*DW]  packed per-requester payload
//   req_rdy [NREQ]                   one-hot accept pulse
//   rsp_vld [NREQ], rsp_data, rsp_err  one-hot completion with result
//   func_address, func_wr_valid, func_rd_valid, func_wr_data  bank request
//   func_ack, func_rd_data           bank read acknowledge and data
// ----------------------------------------------------------------------------
module cae_csr_arb
    import cae_csr_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = 16,
    parameter int DW      = 64,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk_csr,
    input  logic               i_csr_reset_n,
    input  logic [NREQ-1:0]    req_vld,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_rdy,
    output logic [NREQ-1:0]    rsp_vld,
    output logic [DW-1:0]      rsp_data,
    output logic               rsp_err,
    output logic [AW-1:0]      func_address,
    output logic               func_wr_valid,
    output logic               func_rd_valid,
    output logic [DW-1:0]      func_wr_data,
    input  logic               func_ack,
    input  logic [DW-1:0]      func_rd_data
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TMAX    = CW'(TIMEOUT);
    localparam logic [IW-1:0]   LAST    = IW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT = NREQ'(1);

    csr_state_t      state_q, state_d;
    logic [IW-1:0]   ptr_q,   ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic            wr_q,    wr_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q,   err_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    cae_rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .vec_i (req_vld),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Sequencer: accept in IDLE, one strobe cycle in ISSUE, optional WAIT for
    // a read ack, then one RESP cycle that also advances the pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    wr_d    = req_wr[pick_idx];
                    addr_d  = req_addr[pick_idx*AW +: AW];
                    wdata_d = req_wdata[pick_idx*DW +: DW];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (wr_q) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (func_ack) begin
                    rdata_d = func_rd_data;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Ack is checked first so a late ack on the terminal count
                // still completes without error.
                cnt_d = (cnt_q == TMAX) ? cnt_q : cnt_q + 1'b1;
                if (func_ack) begin
                    rdata_d = func_rd_data;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == TMAX) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                ptr_d   = (grant_q == LAST) ? '0 : grant_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any access in flight.
    always_ff @(posedge clk_csr or negedge i_csr_reset_n) begin
        if (!i_csr_reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Strobes and pulses decode from registered state, so they drop the
    // moment reset asserts.
    assign req_rdy       = (state_q == ST_IDLE) ? pick_gnt : '0;
    assign rsp_vld       = (state_q == ST_RESP) ? (ONE_HOT << grant_q) : '0;
    assign rsp_data      = rdata_q;
    assign rsp_err       = err_q;
    assign func_address  = addr_q;
    assign func_wr_data  = wdata_q;
    assign func_wr_valid = (state_q == ST_ISSUE) &&  wr_q;
    assign func_rd_valid = (state_q == ST_ISSUE) && !wr_q;

endmodule

// File: tb/tb_cae_csr_arb.sv
// ----------------------------------------------------------------------------
// tb_cae_csr_arb
// Directed bench for cae_csr_arb with a simple CSR bank model and a
// response scoreboard.
// ----------------------------------------------------------------------------
module tb_cae_csr_arb;
    import cae_csr_pkg::*;

    localparam int NREQ    = 2;
    localparam int AW      = 16;
    localparam int DW      = 64;
    localparam int TIMEOUT = 15;

    logic               clk_csr       = 1'b0;
    logic               i_csr_reset_n = 1'b0;
    logic [NREQ-1:0]    req_vld   = '0;
    logic [NREQ-1:0]    req_wr    = '0;
    logic [NREQ*AW-1:0] req_addr  = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]    req_rdy;
    logic [NREQ-1:0]    rsp_vld;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;
    logic [AW-1:0]      func_address;
    logic               func_wr_valid;
    logic               func_rd_valid;
    logic [DW-1:0]      func_wr_data;
    logic               func_ack;
    logic [DW-1:0]      func_rd_data;

    typedef struct {
        int          idx;
        logic [63:0] data;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   checkCount   = 0;
    int   passCount    = 0;
    int   cycle        = 0;
    int   lastRspCycle = -1;
    int   rspSeen      = 0;
    int   ackDelay     = 0;
    int   sinceStrobe  = 0;

    logic [63:0] bankMem [0:15] = '{3: 64'hDEAD_BEEF_0123_4567, 5: 64'h1, default: 64'h0};

    cae_csr_arb #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_csr       (clk_csr),
        .i_csr_reset_n (i_csr_reset_n),
        .req_vld       (req_vld),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rdy       (req_rdy),
        .rsp_vld       (rsp_vld),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .func_address  (func_address),
        .func_wr_valid (func_wr_valid),
        .func_rd_valid (func_rd_valid),
        .func_wr_data  (func_wr_data),
        .func_ack      (func_ack),
        .func_rd_data  (func_rd_data)
    );

    // 100 MHz CSR clock
    always #5 clk_csr = ~clk_csr;

    // Free-running cycle count used to measure latencies
    always @(posedge clk_csr) cycle <= cycle + 1;

    // Bank model: writes land in a small memory; read acks come either in the
    // strobe cycle (ackDelay 0), ackDelay cycles after it, or never (< 0).
    always @(posedge clk_csr) begin
        if (func_wr_valid) bankMem[func_address[3:0]] <= func_wr_data;
        if (func_rd_valid) sinceStrobe <= 1;
        else if (sinceStrobe != 0) sinceStrobe <= sinceStrobe + 1;
    end

    assign func_ack     = (ackDelay == 0) ? func_rd_valid
                                          : ((ackDelay > 0) && (sinceStrobe == ackDelay));
    assign func_rd_data = func_ack ? bankMem[func_address[3:0]] : 64'hBAD0_BAD0_BAD0_BAD0;

    // One comparison: counts it, and reports tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Response monitor: every rsp_vld pulse must match the oldest expectation
    always @(negedge clk_csr) begin
        rsp_t e;
        if (rsp_vld !== '0) begin
            lastRspCycle = cycle;
            rspSeen++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_rsp", 64'(rsp_vld), 64'h0);
            end else begin
                e = sb.pop_front();
                checkOutput("rsp_vld",  64'(rsp_vld), 64'd1 << e.idx);
                checkOutput("rsp_data", rsp_data, e.data);
                checkOutput("rsp_err",  64'(rsp_err), 64'(e.err));
            end
        end
    end

    // Raise one request, wait (bounded) for its accept, queue the expected
    // response, then drop the request. Returns at the strobe-cycle negedge.
    task automatic applyStimulus(input int idx, input logic wr, input logic [15:0] addr,
                                 input logic [63:0] wdata, input logic [63:0] expData,
                                 input logic expErr, output int acceptCycle);
        bit   got = 1'b0;
        rsp_t e;
        @(negedge clk_csr);
        req_wr[idx]               = wr;
        req_addr[idx*AW +: AW]    = addr;
        req_wdata[idx*DW +: DW]   = wdata;
        req_vld[idx]              = 1'b1;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (req_rdy[idx]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_csr);
        end
        checkOutput("accept_seen", 64'(got), 64'h1);
        checkOutput("req_rdy_onehot", 64'(req_rdy), 64'd1 << idx);
        acceptCycle = cycle;
        e.idx  = idx;
        e.data = expData;
        e.err  = expErr;
        sb.push_back(e);
        @(negedge clk_csr);
        req_vld[idx] = 1'b0;
    endtask

    // Bounded wait for the scoreboard to drain
    task automatic waitRsp();
        bit done = 1'b0;
        for (int n = 0; n < 60; n++) begin
            #1;
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk_csr);
        end
        checkOutput("rsp_arrived", 64'(done), 64'h1);
    endtask

    // Last-resort guard so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        int tAcc;
        int nGrant;
        int prevAcc;
        int seenBefore;
        rsp_t e;

        // Reset values
        repeat (3) @(negedge clk_csr);
        #1;
        checkOutput("reset_req_rdy",  64'(req_rdy), 64'h0);
        checkOutput("reset_rsp_vld",  64'(rsp_vld), 64'h0);
        checkOutput("reset_rsp_data", rsp_data, 64'h0);
        checkOutput("reset_rsp_err",  64'(rsp_err), 64'h0);
        checkOutput("reset_addr",     64'(func_address), 64'h0);
        checkOutput("reset_wr_vld",   64'(func_wr_valid), 64'h0);
        checkOutput("reset_rd_vld",   64'(func_rd_valid), 64'h0);
        checkOutput("reset_wr_data",  func_wr_data, 64'h0);
        i_csr_reset_n = 1'b1;
        repeat (2) @(negedge clk_csr);

        // Read SCRATCH with a same-cycle ack
        $display("[TB] read SCRATCH, same-cycle ack");
        ackDelay = 0;
        applyStimulus(0, 1'b0, CSR_SCRATCH, 64'h0, 64'hDEAD_BEEF_0123_4567, 1'b0, tAcc);
        #1;
        checkOutput("t1_rd_strobe", 64'(func_rd_valid), 64'h1);
        checkOutput("t1_wr_strobe", 64'(func_wr_valid), 64'h0);
        checkOutput("t1_address",   64'(func_address), 64'(CSR_SCRATCH));
        waitRsp();
        checkOutput("t1_latency", 64'(lastRspCycle - tAcc), 64'd2);

        // Write SCRATCH from requester 1, then read it back
        $display("[TB] write/readback SCRATCH");
        applyStimulus(1, 1'b1, CSR_SCRATCH, 64'h5A5A, 64'h0, 1'b0, tAcc);
        #1;
        checkOutput("t2_wr_strobe", 64'(func_wr_valid), 64'h1);
        checkOutput("t2_rd_strobe", 64'(func_rd_valid), 64'h0);
        checkOutput("t2_wr_data",   func_wr_data, 64'h5A5A);
        checkOutput("t2_address",   64'(func_address), 64'(CSR_SCRATCH));
        @(negedge clk_csr);
        #1;
        checkOutput("t2_wr_strobe_off", 64'(func_wr_valid), 64'h0);
        waitRsp();
        checkOutput("t2_latency", 64'(lastRspCycle - tAcc), 64'd2);
        applyStimulus(1, 1'b0, CSR_SCRATCH, 64'h0, 64'h5A5A, 1'b0, tAcc);
        waitRsp();
        checkOutput("t2_rb_latency", 64'(lastRspCycle - tAcc), 64'd2);

        // Contention: both requesters write continuously for six accesses
        $display("[TB] contention, six accesses");
        @(negedge clk_csr);
        req_wr    = '1;
        req_addr  = {16'h0006, 16'h0004};
        req_wdata = {64'h11, 64'h10};
        req_vld   = '1;
        nGrant    = 0;
        prevAcc   = 0;
        for (int n = 0; n < 60 && nGrant < 6; n++) begin
            #1;
            if (req_rdy !== '0) begin
                checkOutput("t3_grant", 64'(req_rdy), 64'd1 << (nGrant % 2));
                if (nGrant > 0) checkOutput("t3_spacing", 64'(cycle - prevAcc), 64'd3);
                e.idx  = nGrant % 2;
                e.data = 64'h0;
                e.err  = 1'b0;
                sb.push_back(e);
                prevAcc = cycle;
                nGrant++;
            end
            @(negedge clk_csr);
        end
        req_vld = '0;
        checkOutput("t3_count", 64'(nGrant), 64'd6);
        waitRsp();

        // Read that is never acknowledged
        $display("[TB] read timeout");
        ackDelay = -1;
        applyStimulus(0, 1'b0, 16'h0009, 64'h0, 64'h0, 1'b1, tAcc);
        waitRsp();
        checkOutput("t4_latency", 64'(lastRspCycle - tAcc), 64'(TIMEOUT + 3));

        // Ack three cycles after the strobe
        $display("[TB] late ack");
        ackDelay = 3;
        applyStimulus(1, 1'b0, 16'h0005, 64'h0, 64'h1, 1'b0, tAcc);
        waitRsp();
        checkOutput("t5_latency", 64'(lastRspCycle - tAcc), 64'd5);

        // Ack on the terminal-count cycle beats the timeout
        $display("[TB] ack on terminal count");
        ackDelay = TIMEOUT + 1;
        applyStimulus(0, 1'b0, 16'h0005, 64'h0, 64'h1, 1'b0, tAcc);
        waitRsp();
        checkOutput("t5b_latency", 64'(lastRspCycle - tAcc), 64'(TIMEOUT + 3));

        // Reset while a read sits in WAIT
        $display("[TB] reset during WAIT");
        ackDelay = -1;
        @(negedge clk_csr);
        req_wr[1]          = 1'b0;
        req_addr[AW +: AW] = 16'h0009;
        req_vld[1]         = 1'b1;
        #1;
        checkOutput("t6_accept", 64'(req_rdy), 64'h2);
        @(negedge clk_csr);
        req_vld = '0;
        repeat (4) @(negedge clk_csr);
        seenBefore    = rspSeen;
        i_csr_reset_n = 1'b0;
        #1;
        checkOutput("t6_rsp_vld",  64'(rsp_vld), 64'h0);
        checkOutput("t6_rsp_data", rsp_data, 64'h0);
        checkOutput("t6_rsp_err",  64'(rsp_err), 64'h0);
        checkOutput("t6_address",  64'(func_address), 64'h0);
        checkOutput("t6_rd_vld",   64'(func_rd_valid), 64'h0);
        checkOutput("t6_wr_vld",   64'(func_wr_valid), 64'h0);
        repeat (2) @(negedge clk_csr);
        i_csr_reset_n = 1'b1;
        repeat (TIMEOUT + 6) @(negedge clk_csr);
        checkOutput("t6_no_rsp", 64'(rspSeen - seenBefore), 64'h0);
        req_wr    = '1;
        req_addr  = {16'h0006, 16'h0004};
        req_wdata = {64'h21, 64'h20};
        req_vld   = '1;
        #1;
        checkOutput("t6_first_grant", 64'(req_rdy), 64'h1);
        e.idx  = 0;
        e.data = 64'h0;
        e.err  = 1'b0;
        sb.push_back(e);
        req_vld[1] = 1'b0;
        @(negedge clk_csr);
        req_vld = '0;
        waitRsp();
        checkOutput("sb_empty", 64'(sb.size()), 64'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
